// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin two-client burst command arbiter for one sdram_core
module sdram_port_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int NUM_W    = 10,
  parameter int DATA_W   = 16,
  parameter int WAIT_MAX = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_cmd_valid,
  output logic              c0_cmd_ready,
  input  logic              c0_cmd_wr,
  input  logic [ADDR_W-1:0] c0_cmd_addr,
  input  logic [NUM_W-1:0]  c0_cmd_num,
  input  logic [DATA_W-1:0] c0_wr_data,
  output logic              c0_wr_allow,
  output logic [DATA_W-1:0] c0_rd_data,
  output logic              c0_rd_valid,
  output logic              c0_done,
  output logic              c0_err,
  input  logic              c1_cmd_valid,
  output logic              c1_cmd_ready,
  input  logic              c1_cmd_wr,
  input  logic [ADDR_W-1:0] c1_cmd_addr,
  input  logic [NUM_W-1:0]  c1_cmd_num,
  input  logic [DATA_W-1:0] c1_wr_data,
  output logic              c1_wr_allow,
  output logic [DATA_W-1:0] c1_rd_data,
  output logic              c1_rd_valid,
  output logic              c1_done,
  output logic              c1_err,
  output logic              core_wr_request,
  output logic              core_rd_request,
  output logic [ADDR_W-1:0] core_wr_addr,
  output logic [ADDR_W-1:0] core_rd_addr,
  output logic [NUM_W-1:0]  core_wr_num,
  output logic [NUM_W-1:0]  core_rd_num,
  output logic [DATA_W-1:0] core_wr_data,
  input  logic              core_wr_allow,
  input  logic              core_rd_allow,
  input  logic [DATA_W-1:0] core_rd_data,
  input  logic              core_busy
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RUN, S_DONE} state_t;

  state_t            state;
  logic              owner;
  logic              last_served;
  logic              wr_q;
  logic              dir_err;
  logic [ADDR_W-1:0] addr_q;
  logic [NUM_W-1:0]  num_q;
  logic [NUM_W-1:0]  beat;
  logic [WC_W-1:0]   wait_cnt;

  logic              any_valid;
  logic              grant;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [NUM_W-1:0]  sel_num;
  logic              active;
  logic              route_wr;
  logic              route_rd;
  logic              bad_dir;
  logic              dir_err_next;
  logic [NUM_W-1:0]  beat_next;
  logic              fin_err;

  // On a tie the client that was not served last wins.
  always_comb begin
    any_valid = c0_cmd_valid | c1_cmd_valid;
    grant     = (c0_cmd_valid && c1_cmd_valid) ? ~last_served : c1_cmd_valid;
    sel_wr    = grant ? c1_cmd_wr   : c0_cmd_wr;
    sel_addr  = grant ? c1_cmd_addr : c0_cmd_addr;
    sel_num   = grant ? c1_cmd_num  : c0_cmd_num;
  end

  always_comb begin
    active       = (state == S_WAIT) || (state == S_RUN);
    route_wr     = active && wr_q && core_wr_allow;
    route_rd     = active && !wr_q && core_rd_allow;
    bad_dir      = active && (wr_q ? core_rd_allow : core_wr_allow);
    dir_err_next = dir_err | bad_dir;
    beat_next    = ((route_wr || route_rd) && (beat != '1)) ? beat + 1'b1 : beat;
    fin_err      = dir_err_next | (beat_next != num_q);
  end

  assign c0_cmd_ready = (state == S_IDLE) && any_valid && !grant;
  assign c1_cmd_ready = (state == S_IDLE) && any_valid && grant;
  assign c0_wr_allow  = route_wr && !owner;
  assign c1_wr_allow  = route_wr && owner;
  assign c0_rd_valid  = route_rd && !owner;
  assign c1_rd_valid  = route_rd && owner;
  assign c0_rd_data   = core_rd_data;
  assign c1_rd_data   = core_rd_data;
  assign core_wr_data = owner ? c1_wr_data : c0_wr_data;
  assign core_wr_addr = addr_q;
  assign core_rd_addr = addr_q;
  assign core_wr_num  = num_q;
  assign core_rd_num  = num_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      owner           <= 1'b0;
      last_served     <= 1'b1;
      wr_q            <= 1'b0;
      dir_err         <= 1'b0;
      addr_q          <= '0;
      num_q           <= '0;
      beat            <= '0;
      wait_cnt        <= '0;
      core_wr_request <= 1'b0;
      core_rd_request <= 1'b0;
      c0_done         <= 1'b0;
      c1_done         <= 1'b0;
      c0_err          <= 1'b0;
      c1_err          <= 1'b0;
    end else begin
      core_wr_request <= 1'b0;
      core_rd_request <= 1'b0;
      c0_done         <= 1'b0;
      c1_done         <= 1'b0;
      c0_err          <= 1'b0;
      c1_err          <= 1'b0;
      if (active) begin
        beat    <= beat_next;
        dir_err <= dir_err_next;
      end
      unique case (state)
        S_IDLE: begin
          if (any_valid) begin
            owner    <= grant;
            wr_q     <= sel_wr;
            addr_q   <= sel_addr;
            num_q    <= sel_num;
            beat     <= '0;
            dir_err  <= 1'b0;
            wait_cnt <= '0;
            // Zero-length bursts never touch the core.
            if (sel_num == '0) begin
              state   <= S_DONE;
              c0_done <= ~grant;
              c1_done <= grant;
            end else begin
              state           <= S_ISSUE;
              core_wr_request <= sel_wr;
              core_rd_request <= ~sel_wr;
            end
          end
        end
        S_ISSUE: begin
          state    <= S_WAIT;
          wait_cnt <= WC_W'(1);
        end
        S_WAIT: begin
          if (core_busy) begin
            state <= S_RUN;
          end else if (wait_cnt == WC_W'(WAIT_MAX)) begin
            state   <= S_DONE;
            c0_done <= ~owner;
            c1_done <= owner;
            c0_err  <= ~owner;
            c1_err  <= owner;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!core_busy) begin
            state   <= S_DONE;
            c0_done <= ~owner;
            c1_done <= owner;
            c0_err  <= ~owner & fin_err;
            c1_err  <= owner & fin_err;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          last_served <= owner;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
